// File: rtl/conv_sched_pkg.sv
// rtl/conv_sched_pkg.sv - shared types and constants for the convolutional subblock scheduler
package conv_sched_pkg;

    localparam int SMALL_BYTES = 132;
    localparam int LARGE_BYTES = 768;
    localparam int CNT_W       = 10;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        READ    = 3'd1,
        CAPTURE = 3'd2,
        SEND0   = 3'd3,
        SEND1   = 3'd4,
        SEND2   = 3'd5,
        FINISH  = 3'd6
    } state_e;

    localparam logic [1:0] STREAM_0 = 2'd0;
    localparam logic [1:0] STREAM_1 = 2'd1;
    localparam logic [1:0] STREAM_2 = 2'd2;

endpackage

// File: rtl/conv_sched_byte_counter.sv
// rtl/conv_sched_byte_counter.sv - per-block byte counter with loadable limit and last flag
module conv_sched_byte_counter #(
    parameter int W = 10
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] limit_in,
    input  logic         clear,
    input  logic         inc,
    output logic [W-1:0] count,
    output logic         last
);

    logic [W-1:0] limit_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            limit_q <= '0;
            count   <= '0;
        end else begin
            if (load)
                limit_q <= limit_in;
            if (clear)
                count <= '0;
            else if (inc)
                count <= count + W'(1);
        end
    end

    // With limit 0 (after reset) limit-1 is all ones, so last stays low
    assign last = (count == (limit_q - W'(1)));

endmodule

// File: rtl/conv_subblock_scheduler.sv
// rtl/conv_subblock_scheduler.sv - reads the three encoder FIFOs per block and serialises d0/d1/d2 bytes
module conv_subblock_scheduler
    import conv_sched_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       enc_done,
    input  logic       enc_length,
    input  logic       enc_empty,
    input  logic [7:0] q0,
    input  logic [7:0] q1,
    input  logic [7:0] q2,
    output logic       rdreq_subblock,
    output logic [7:0] out_data,
    output logic [1:0] out_stream,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       out_sob,
    output logic       out_eob,
    output logic       busy,
    output logic       blk_done,
    output logic       err
);

    state_e             state, state_n;
    logic               pend_q, pend_n;
    logic               pend_len_q, pend_len_n;
    logic               err_n;
    logic [7:0]         buf0, buf1, buf2;
    logic               start, start_len, inc;
    logic [CNT_W-1:0]   count;
    logic               last;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            pend_q     <= 1'b0;
            pend_len_q <= 1'b0;
            err        <= 1'b0;
            buf0       <= '0;
            buf1       <= '0;
            buf2       <= '0;
        end else begin
            state      <= state_n;
            pend_q     <= pend_n;
            pend_len_q <= pend_len_n;
            err        <= err_n;
            if (state == CAPTURE) begin
                buf0 <= q0;
                buf1 <= q1;
                buf2 <= q2;
            end
        end
    end

    conv_sched_byte_counter #(.W(CNT_W)) u_cnt (
        .clk      (clk),
        .reset    (reset),
        .load     (start),
        .limit_in (start_len ? CNT_W'(LARGE_BYTES) : CNT_W'(SMALL_BYTES)),
        .clear    (start),
        .inc      (inc),
        .count    (count),
        .last     (last)
    );

    always_comb begin
        state_n        = state;
        pend_n         = pend_q;
        pend_len_n     = pend_len_q;
        err_n          = err;
        start          = 1'b0;
        start_len      = enc_length;
        inc            = 1'b0;
        rdreq_subblock = 1'b0;
        out_valid      = 1'b0;
        out_data       = '0;
        out_stream     = STREAM_0;
        out_sob        = 1'b0;
        out_eob        = 1'b0;
        busy           = 1'b0;
        blk_done       = 1'b0;

        // A queued request wins over a fresh enc_done, which then becomes the new queued one
        if (state == IDLE) begin
            if (pend_q) begin
                start      = 1'b1;
                start_len  = pend_len_q;
                pend_n     = enc_done;
                pend_len_n = enc_length;
            end else if (enc_done) begin
                start = 1'b1;
            end
            if (start)
                state_n = READ;
        end else if (enc_done) begin
            if (pend_q) begin
                err_n = 1'b1;
            end else begin
                pend_n     = 1'b1;
                pend_len_n = enc_length;
            end
        end

        case (state)
            IDLE: ;
            READ: begin
                busy = 1'b1;
                if (enc_empty) begin
                    err_n    = 1'b1;
                    blk_done = 1'b1;
                    state_n  = IDLE;
                end else begin
                    rdreq_subblock = 1'b1;
                    state_n        = CAPTURE;
                end
            end
            CAPTURE: begin
                busy    = 1'b1;
                state_n = SEND0;
            end
            SEND0: begin
                busy       = 1'b1;
                out_valid  = 1'b1;
                out_data   = buf0;
                out_stream = STREAM_0;
                out_sob    = (count == '0);
                if (out_ready)
                    state_n = SEND1;
            end
            SEND1: begin
                busy       = 1'b1;
                out_valid  = 1'b1;
                out_data   = buf1;
                out_stream = STREAM_1;
                if (out_ready)
                    state_n = SEND2;
            end
            SEND2: begin
                busy       = 1'b1;
                out_valid  = 1'b1;
                out_data   = buf2;
                out_stream = STREAM_2;
                out_eob    = last;
                if (out_ready) begin
                    inc     = 1'b1;
                    state_n = last ? FINISH : READ;
                end
            end
            FINISH: begin
                blk_done = 1'b1;
                state_n  = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: tb/tb_conv_subblock_scheduler.sv
// tb/tb_conv_subblock_scheduler.sv - directed self-checking bench for conv_subblock_scheduler
module tb_conv_subblock_scheduler;
    import conv_sched_pkg::*;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       enc_done = 1'b0;
    logic       enc_length = 1'b0;
    logic       enc_empty;
    logic [7:0] q0 = 8'h00;
    logic [7:0] q1 = 8'h00;
    logic [7:0] q2 = 8'h00;
    logic       rdreq_subblock;
    logic [7:0] out_data;
    logic [1:0] out_stream;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic       out_sob, out_eob, busy, blk_done, err;

    int checks = 0;
    int passed = 0;

    // FIFO model: three streams share one read pointer
    int rd_idx = 0;
    int fifo_start = 0;
    int fifo_end = 0;

    // Monitor tallies (cumulative) and per-test snapshots
    int cyc = 0;
    int beats = 0, bad_beats = 0, stall_bad = 0, stall_cycles = 0;
    int rd_pulses = 0, rd_bad = 0, blk_pulses = 0, sob_cnt = 0, eob_cnt = 0;
    int last_sob_beat = -1, last_eob_beat = -1;
    int done_cyc = 0, first_rd_cyc = 0, second_rd_cyc = 0, first_blk_cyc = 0, first_beat_cyc = 0;
    logic       prev_stall = 1'b0;
    logic [7:0] prev_data = 8'h00;
    logic [1:0] prev_stream = 2'd0;
    int beat_base = 0, rd_base = 0, blk_base = 0, bad0 = 0, stall0 = 0, stallc0 = 0;
    int sob0 = 0, eob0 = 0, rdbad0 = 0;

    conv_subblock_scheduler dut (
        .clk            (clk),
        .reset          (reset),
        .enc_done       (enc_done),
        .enc_length     (enc_length),
        .enc_empty      (enc_empty),
        .q0             (q0),
        .q1             (q1),
        .q2             (q2),
        .rdreq_subblock (rdreq_subblock),
        .out_data       (out_data),
        .out_stream     (out_stream),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_sob        (out_sob),
        .out_eob        (out_eob),
        .busy           (busy),
        .blk_done       (blk_done),
        .err            (err)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] pat(input int s, input int k);
        logic [7:0] kb;
        kb = k[7:0];
        if (s == 0) return kb;
        if (s == 1) return 8'h80 | kb;
        return 8'h40 | kb;
    endfunction

    assign enc_empty = (rd_idx == fifo_end);

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rdreq_subblock && !enc_empty) begin
            q0     <= pat(0, rd_idx - fifo_start);
            q1     <= pat(1, rd_idx - fifo_start);
            q2     <= pat(2, rd_idx - fifo_start);
            rd_idx <= rd_idx + 1;
        end
    end

    always @(negedge clk) begin : mon
        int n;
        if (rdreq_subblock) begin
            if (enc_empty) rd_bad <= rd_bad + 1;
            if (rd_pulses - rd_base == 0) first_rd_cyc <= cyc;
            if (rd_pulses - rd_base == SMALL_BYTES) second_rd_cyc <= cyc;
            rd_pulses <= rd_pulses + 1;
        end
        if (enc_done) done_cyc <= cyc;
        if (blk_done) begin
            if (blk_pulses - blk_base == 0) first_blk_cyc <= cyc;
            blk_pulses <= blk_pulses + 1;
        end
        if (prev_stall && !(out_valid && out_data == prev_data && out_stream == prev_stream))
            stall_bad <= stall_bad + 1;
        if (out_valid && !out_ready) stall_cycles <= stall_cycles + 1;
        prev_stall  <= out_valid && !out_ready;
        prev_data   <= out_data;
        prev_stream <= out_stream;
        if (out_valid && out_ready) begin
            n = beats - beat_base;
            if (out_stream !== 2'(n % 3) || out_data !== pat(n % 3, n / 3))
                bad_beats <= bad_beats + 1;
            if (out_sob) begin sob_cnt <= sob_cnt + 1; last_sob_beat <= n; end
            if (out_eob) begin eob_cnt <= eob_cnt + 1; last_eob_beat <= n; end
            if (n == 0) first_beat_cyc <= cyc;
            beats <= beats + 1;
        end
    end

    task automatic mark(input int nbytes);
        beat_base = beats; rd_base = rd_pulses; blk_base = blk_pulses;
        bad0 = bad_beats; stall0 = stall_bad; stallc0 = stall_cycles;
        sob0 = sob_cnt; eob0 = eob_cnt; rdbad0 = rd_bad;
        fifo_start = rd_idx; fifo_end = rd_idx + nbytes;
    endtask

    task automatic pulse(input logic len);
        enc_done = 1'b1; enc_length = len;
        @(posedge clk); #1;
        enc_done = 1'b0;
    endtask

    task automatic wait_blocks(input int nblk, input int budget, input bit rnd, output bit timeout);
        int c;
        c = 0;
        timeout = 1'b0;
        while (blk_pulses - blk_base < nblk) begin
            if (c == budget) begin timeout = 1'b1; break; end
            out_ready = rnd ? ($urandom_range(0, 9) < 3) : 1'b1;
            @(posedge clk); #1;
            c++;
        end
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic wait_beats(input int nb, output bit timeout);
        int c;
        c = 0;
        timeout = 1'b0;
        while (beats - beat_base < nb) begin
            if (c == 1000) begin timeout = 1'b1; break; end
            @(posedge clk); #1;
            c++;
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        checks++; if ({rdreq_subblock, out_valid, out_sob, out_eob, busy, blk_done, err, out_data, out_stream} !== 17'd0)
            $display("FAIL reset_outputs: got %b expected all zero", {rdreq_subblock, out_valid, out_sob, out_eob, busy, blk_done, err, out_data, out_stream}); else passed++;
        checks++; if (dut.state !== IDLE) $display("FAIL reset_state: got %0d expected %0d", dut.state, IDLE); else passed++;
    endtask

    task automatic test_small;
        bit to;
        mark(SMALL_BYTES);
        out_ready = 1'b1;
        pulse(1'b0);
        wait_blocks(1, 2000, 1'b0, to);
        checks++; if (to) $display("FAIL small_timeout: got timeout expected blk_done"); else passed++;
        checks++; if (beats - beat_base !== 396) $display("FAIL small_beats: got %0d expected 396", beats - beat_base); else passed++;
        checks++; if (bad_beats - bad0 !== 0) $display("FAIL small_order: got %0d bad beats expected 0", bad_beats - bad0); else passed++;
        checks++; if (sob_cnt - sob0 !== 1 || last_sob_beat !== 0) $display("FAIL small_sob: got cnt %0d at %0d expected 1 at 0", sob_cnt - sob0, last_sob_beat); else passed++;
        checks++; if (eob_cnt - eob0 !== 1 || last_eob_beat !== 395) $display("FAIL small_eob: got cnt %0d at %0d expected 1 at 395", eob_cnt - eob0, last_eob_beat); else passed++;
        checks++; if (rd_pulses - rd_base !== 132) $display("FAIL small_rdreq: got %0d expected 132", rd_pulses - rd_base); else passed++;
        checks++; if (blk_pulses - blk_base !== 1) $display("FAIL small_blk_done: got %0d expected 1", blk_pulses - blk_base); else passed++;
        checks++; if (first_rd_cyc - done_cyc !== 1) $display("FAIL small_rd_latency: got %0d expected 1", first_rd_cyc - done_cyc); else passed++;
        checks++; if (first_beat_cyc - done_cyc !== 3) $display("FAIL small_valid_latency: got %0d expected 3", first_beat_cyc - done_cyc); else passed++;
        checks++; if (busy !== 1'b0 || err !== 1'b0) $display("FAIL small_idle: got busy %b err %b expected 0 0", busy, err); else passed++;
    endtask

    task automatic test_large;
        bit to;
        mark(LARGE_BYTES);
        pulse(1'b1);
        wait_blocks(1, 6000, 1'b0, to);
        checks++; if (to) $display("FAIL large_timeout: got timeout expected blk_done"); else passed++;
        checks++; if (beats - beat_base !== 2304) $display("FAIL large_beats: got %0d expected 2304", beats - beat_base); else passed++;
        checks++; if (bad_beats - bad0 !== 0) $display("FAIL large_order: got %0d bad beats expected 0", bad_beats - bad0); else passed++;
        checks++; if (rd_pulses - rd_base !== 768) $display("FAIL large_rdreq: got %0d expected 768", rd_pulses - rd_base); else passed++;
        checks++; if (eob_cnt - eob0 !== 1 || last_eob_beat !== 2303) $display("FAIL large_eob: got cnt %0d at %0d expected 1 at 2303", eob_cnt - eob0, last_eob_beat); else passed++;
        checks++; if (err !== 1'b0 || rd_bad - rdbad0 !== 0) $display("FAIL large_err: got err %b underreads %0d expected 0 0", err, rd_bad - rdbad0); else passed++;
    endtask

    task automatic test_backpressure;
        bit to;
        mark(SMALL_BYTES);
        out_ready = 1'b0;
        pulse(1'b0);
        wait_blocks(1, 8000, 1'b1, to);
        checks++; if (to) $display("FAIL bp_timeout: got timeout expected blk_done"); else passed++;
        checks++; if (beats - beat_base !== 396) $display("FAIL bp_beats: got %0d expected 396", beats - beat_base); else passed++;
        checks++; if (bad_beats - bad0 !== 0) $display("FAIL bp_order: got %0d bad beats expected 0", bad_beats - bad0); else passed++;
        checks++; if (stall_bad - stall0 !== 0) $display("FAIL bp_stable: got %0d unstable stalls expected 0", stall_bad - stall0); else passed++;
        checks++; if (stall_cycles - stallc0 < 50) $display("FAIL bp_stalled: got %0d stall cycles expected at least 50", stall_cycles - stallc0); else passed++;
        checks++; if (rd_pulses - rd_base !== 132) $display("FAIL bp_rdreq: got %0d expected 132", rd_pulses - rd_base); else passed++;
    endtask

    task automatic test_back_to_back;
        bit to;
        mark(SMALL_BYTES + LARGE_BYTES);
        out_ready = 1'b1;
        pulse(1'b0);
        wait_beats(10, to);
        pulse(1'b1);
        checks++; if (dut.pend_q !== 1'b1 || err !== 1'b0) $display("FAIL b2b_pending: got pend %b err %b expected 1 0", dut.pend_q, err); else passed++;
        pulse(1'b1);
        checks++; if (err !== 1'b1) $display("FAIL b2b_overflow_err: got %b expected 1", err); else passed++;
        wait_blocks(2, 8000, 1'b0, to);
        checks++; if (to) $display("FAIL b2b_timeout: got timeout expected two blk_done"); else passed++;
        checks++; if (beats - beat_base !== 2700) $display("FAIL b2b_beats: got %0d expected 2700", beats - beat_base); else passed++;
        checks++; if (bad_beats - bad0 !== 0) $display("FAIL b2b_order: got %0d bad beats expected 0", bad_beats - bad0); else passed++;
        checks++; if (rd_pulses - rd_base !== 900) $display("FAIL b2b_rdreq: got %0d expected 900", rd_pulses - rd_base); else passed++;
        checks++; if (sob_cnt - sob0 !== 2 || last_sob_beat !== 396) $display("FAIL b2b_sob: got cnt %0d at %0d expected 2 at 396", sob_cnt - sob0, last_sob_beat); else passed++;
        checks++; if (eob_cnt - eob0 !== 2 || last_eob_beat !== 2699) $display("FAIL b2b_eob: got cnt %0d at %0d expected 2 at 2699", eob_cnt - eob0, last_eob_beat); else passed++;
        checks++; if (second_rd_cyc - first_blk_cyc !== 2) $display("FAIL b2b_restart: got %0d expected 2", second_rd_cyc - first_blk_cyc); else passed++;
        checks++; if (blk_pulses - blk_base !== 2 || busy !== 1'b0 || dut.pend_q !== 1'b0) $display("FAIL b2b_end: got blk %0d busy %b pend %b expected 2 0 0", blk_pulses - blk_base, busy, dut.pend_q); else passed++;
    endtask

    task automatic test_underflow;
        bit to;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        mark(10);
        pulse(1'b0);
        wait_blocks(1, 500, 1'b0, to);
        checks++; if (to) $display("FAIL uf_timeout: got timeout expected blk_done"); else passed++;
        checks++; if (beats - beat_base !== 30 || rd_pulses - rd_base !== 10) $display("FAIL uf_counts: got beats %0d reads %0d expected 30 10", beats - beat_base, rd_pulses - rd_base); else passed++;
        checks++; if (err !== 1'b1) $display("FAIL uf_err: got %b expected 1", err); else passed++;
        checks++; if (blk_pulses - blk_base !== 1 || busy !== 1'b0 || dut.state !== IDLE) $display("FAIL uf_idle: got blk %0d busy %b state %0d expected 1 0 0", blk_pulses - blk_base, busy, dut.state); else passed++;
    endtask

    task automatic test_reset_mid;
        bit to;
        mark(SMALL_BYTES);
        out_ready = 1'b1;
        pulse(1'b0);
        wait_beats(50, to);
        checks++; if (to) $display("FAIL rst_mid_timeout: got timeout expected 50 beats"); else passed++;
        pulse(1'b0);
        checks++; if (dut.pend_q !== 1'b1) $display("FAIL rst_mid_pending: got %b expected 1", dut.pend_q); else passed++;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        checks++; if ({rdreq_subblock, out_valid, out_sob, out_eob, busy, blk_done, err, out_data, out_stream} !== 17'd0)
            $display("FAIL rst_mid_outputs: got %b expected all zero", {rdreq_subblock, out_valid, out_sob, out_eob, busy, blk_done, err, out_data, out_stream}); else passed++;
        checks++; if (dut.state !== IDLE || dut.pend_q !== 1'b0) $display("FAIL rst_mid_state: got state %0d pend %b expected 0 0", dut.state, dut.pend_q); else passed++;
        mark(SMALL_BYTES);
        pulse(1'b0);
        wait_blocks(1, 2000, 1'b0, to);
        checks++; if (to) $display("FAIL restart_timeout: got timeout expected blk_done"); else passed++;
        checks++; if (beats - beat_base !== 396 || bad_beats - bad0 !== 0) $display("FAIL restart_beats: got %0d beats %0d bad expected 396 0", beats - beat_base, bad_beats - bad0); else passed++;
        checks++; if (rd_pulses - rd_base !== 132 || err !== 1'b0) $display("FAIL restart_rdreq: got %0d reads err %b expected 132 0", rd_pulses - rd_base, err); else passed++;
    endtask

    initial begin
        test_reset();
        test_small();
        test_large();
        test_backpressure();
        test_back_to_back();
        test_underflow();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
